alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Registered two-requester controller for the shared picoMIPS ALU. It accepts operation requests (operands plus 3-bit function code) from two clients, grants them round-robin, and drives the combinational `alu` instance through a fixed IDLE→EXEC→DONE sequence. It captures `result`/`flag` and returns them to the granted client with a one-cycle done pulse. It sits between the datapath control logic (or a debug/IO port) and the single `alu` instance, so the ALU is never driven by two sources.

## Interface
- `n`, default 8: data bus width, must match the attached `alu` instance.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  2  per-client request level; bit i = client i.
- `a0`, `b0`  in  n each  client 0 operands.
- `func0`  in  3  client 0 ALU code (`alucodes.sv` values: RLD, RADD, RADDI, RMUL, RBEQ, RBNE …).
- `a1`, `b1`  in  n each  client 1 operands.
- `func1`  in  3  client 1 ALU code.
- `done`  out  2  one-cycle pulse on the served client's bit.
- `result`  out  n  captured ALU result, held until next capture.
- `flag`  out  1  captured ALU flag, held until next capture.
- `gnt_id`  out  1  client currently or last served.
- `busy`  out  1  high in EXEC and DONE.
- `alu_a`, `alu_b`  out  n each  registered operands to the ALU.
- `alu_func`  out  3  registered function code to the ALU.
- `alu_result`  in  n  ALU result.
- `alu_flag`  in  1  ALU flag.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any `req` bit is high at the clock edge, pick a winner, latch its `a`/`b`/`func` into `alu_a`/`alu_b`/`alu_func`, set `gnt_id`, and go to EXEC. With no request, stay in IDLE.
- Arbitration is round-robin:
  - Single request: that client wins.
  - Both requesting: the client ≠ `last_gnt` wins.
  - `last_gnt` updates on each grant and resets to 1, so client 0 wins the first tie.
- EXEC: hold `alu_*` stable. At the edge ending EXEC, capture `alu_result` into `result` and `alu_flag` into `flag`, set `done[gnt_id]`, and go to DONE.
- DONE: `done` is high for this cycle only; return to IDLE at the next edge.
- Clients hold `req` and operands stable from assertion until they see `done`. Operands are sampled only at the grant edge.
- A client that drops `req` during EXEC/DONE does not cancel the operation. It still gets `done`, and the result is captured.
- A client that keeps `req` high after `done` is re-arbitrated in the following IDLE cycle. Round-robin then favours the other client if it is requesting.
- No arithmetic is done in this block. Width and fixed-point semantics (e.g. RMUL fractional `a` × integer `b`, truncated) belong entirely to `alu`.
- Reset, in any state: state→IDLE and `last_gnt`→1. All outputs are zero: `done`=0, `result`=0, `flag`=0, `gnt_id`=0, `busy`=0, `alu_a`=0, `alu_b`=0, `alu_func`=3'b000.
- Reset mid-EXEC: the in-flight operation is dropped, with no capture and no `done`.

## Timing
- Grant edge E0 (IDLE, `req` high) → `alu_*` valid after E0.
- Capture at E1 → `result`/`flag`/`done` valid in the cycle after E1.
- Return to IDLE at E2. Earliest next grant at E3.
- Request-to-done latency: 2 edges. Throughput: one operation per 3 cycles.
- `alu` is combinational and must settle within one cycle; EXEC provides that full cycle.
- `result`/`flag` change only at capture edges or reset.
- `busy` = (state ≠ IDLE), registered with state.

## Test plan
- Client 0 only: a0=4, b0=8, func0=RADD.
  - Expect `done`=2'b01 exactly 2 edges after grant.
  - `result`=12.
  - `busy` high for 2 cycles.
- Client 1 RMUL: a1=8'h60 (0.75), b1=8'h06 → `result`=8'h04. Then a1=8'hE0 (−0.25), b1=8'h14 → `result`=8'hFB (−5).
- Both `req` high continuously after reset:
  - Grants alternate 0,1,0,1.
  - `done` bits alternate; each `done` is 1 cycle wide and 3 cycles apart.
- Flag operations:
  - Client 0 RBEQ a=0, b=0 → `flag`=1.
  - Client 1 RBNE a=1, b=0 → `flag`=0.
  - `flag`/`result` hold value through the following idle cycles.
- `reset` asserted in EXEC:
  - Next cycle all outputs are 0 and `done` never pulses.
  - After release, a tie grants client 0 first.
- Client 0 drops `req` in EXEC → `done[0]` still pulses with the correct result. No spurious re-grant occurs.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared picoMIPS ALU: two clients, fixed
// IDLE->EXEC->DONE sequence, registered ALU operands and captured result/flag.
module alu_arbiter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [n-1:0] a0,
  input  logic [n-1:0] b0,
  input  logic [2:0]   func0,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] b1,
  input  logic [2:0]   func1,
  output logic [1:0]   done,
  output logic [n-1:0] result,
  output logic         flag,
  output logic         gnt_id,
  output logic         busy,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [2:0]   alu_func,
  input  logic [n-1:0] alu_result,
  input  logic         alu_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state_q, state_d;
  logic         last_gnt_q, last_gnt_d;
  logic         gnt_id_q, gnt_id_d;
  logic         busy_q, busy_d;
  logic [1:0]   done_q, done_d;
  logic [n-1:0] result_q, result_d;
  logic         flag_q, flag_d;
  logic [n-1:0] alu_a_q, alu_a_d;
  logic [n-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_func_q, alu_func_d;
  logic         win;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    done_d     = 2'b00;
    result_d   = result_q;
    flag_d     = flag_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    // On a tie the client that was not served last wins.
    win = (req == 2'b11) ? ~last_gnt_q : req[1];
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = EXEC;
          gnt_id_d   = win;
          last_gnt_d = win;
          alu_a_d    = win ? a1 : a0;
          alu_b_d    = win ? b1 : b0;
          alu_func_d = win ? func1 : func0;
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = alu_result;
        flag_d   = alu_flag;
        done_d   = gnt_id_q ? 2'b10 : 2'b01;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 2'b00;
      result_q   <= '0;
      flag_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      flag_q     <= flag_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign flag     = flag_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural picoMIPS ALU attached.
module tb_alu_arbiter;
  localparam int N = 8;
  localparam logic [2:0] RLD = 3'd0, RADD = 3'd1, RADDI = 3'd2, RMUL = 3'd3,
                         RBEQ = 3'd4, RBNE = 3'd5;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [N-1:0] a0, b0, a1, b1;
  logic [2:0]   func0, func1;
  logic [1:0]   done;
  logic [N-1:0] result;
  logic         flag, gnt_id, busy;
  logic [N-1:0] alu_a, alu_b;
  logic [2:0]   alu_func;
  logic [N-1:0] alu_result;
  logic         alu_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.n(N)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .func0(func0),
    .a1(a1), .b1(b1), .func1(func1),
    .done(done), .result(result), .flag(flag), .gnt_id(gnt_id), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_flag(alu_flag)
  );

  // ALU environment: RMUL is signed Q1.7 a times signed integer b, truncated.
  logic signed [15:0] prod;
  always_comb begin
    prod       = $signed(alu_a) * $signed(alu_b);
    alu_result = alu_b;
    alu_flag   = 1'b0;
    case (alu_func)
      RADD, RADDI: alu_result = alu_a + alu_b;
      RMUL:        alu_result = 8'(prod >>> 7);
      RBEQ, RBNE: begin
        alu_result = alu_a - alu_b;
        alu_flag   = (alu_a == alu_b);
      end
      default:     alu_result = alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, b0;
    logic [2:0] f0;
    logic [7:0] a1, b1;
    logic [2:0] f1;
    logic       gnt;
    logic [7:0] res;
    logic       flg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0] exp_done;
    vecs[0] = '{2'b01, 8'd4,  8'd8,  RADD, 8'd0,  8'd0,  RLD,  1'b0, 8'd12,  1'b0};
    vecs[1] = '{2'b10, 8'd0,  8'd0,  RLD,  8'h60, 8'h06, RMUL, 1'b1, 8'h04,  1'b0};
    vecs[2] = '{2'b10, 8'd0,  8'd0,  RLD,  8'hE0, 8'h14, RMUL, 1'b1, 8'hFB,  1'b0};
    vecs[3] = '{2'b01, 8'd0,  8'd0,  RBEQ, 8'd0,  8'd0,  RLD,  1'b0, 8'd0,   1'b1};
    vecs[4] = '{2'b10, 8'd0,  8'd0,  RLD,  8'd1,  8'd0,  RBNE, 1'b1, 8'd1,   1'b0};
    vecs[5] = '{2'b11, 8'd3,  8'd5,  RADD, 8'd10, 8'd20, RADD, 1'b0, 8'd8,   1'b0};
    vecs[6] = '{2'b11, 8'd3,  8'd5,  RADD, 8'd10, 8'd20, RADD, 1'b1, 8'd30,  1'b0};
    vecs[7] = '{2'b11, 8'd7,  8'd7,  RBEQ, 8'd10, 8'd20, RADD, 1'b0, 8'd0,   1'b1};

    reset = 1'b1; req = 2'b00;
    a0 = 0; b0 = 0; func0 = RLD; a1 = 0; b1 = 0; func1 = RLD;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);     chk("rst_result", result, 0);
    chk("rst_flag", flag, 0);     chk("rst_gnt", gnt_id, 0);
    chk("rst_busy", busy, 0);     chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);   chk("rst_alu_func", alu_func, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single operations and ties, each started from IDLE.
    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req;
      a0 = vecs[i].a0; b0 = vecs[i].b0; func0 = vecs[i].f0;
      a1 = vecs[i].a1; b1 = vecs[i].b1; func1 = vecs[i].f1;
      exp_done = vecs[i].gnt ? 2'b10 : 2'b01;
      @(negedge clk);
      chk($sformatf("v%0d_exec_busy", i), busy, 1);
      chk($sformatf("v%0d_gnt", i), gnt_id, vecs[i].gnt);
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].gnt ? vecs[i].a1 : vecs[i].a0);
      chk($sformatf("v%0d_alu_func", i), alu_func, vecs[i].gnt ? vecs[i].f1 : vecs[i].f0);
      chk($sformatf("v%0d_exec_done", i), done, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done", i), done, exp_done);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_flag", i), flag, vecs[i].flg);
      chk($sformatf("v%0d_done_busy", i), busy, 1);
      req = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_idle_done", i), done, 0);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // Result and flag hold through idle cycles while inputs wander.
    for (int k = 0; k < 3; k++) begin
      a0 = 8'hAA + 8'(k); b0 = 8'h55; a1 = 8'h11; b1 = 8'h22;
      @(negedge clk);
      chk("hold_result", result, 8'd0);
      chk("hold_flag", flag, 1);
      chk("hold_done", done, 0);
    end

    // Both clients requesting continuously from reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 2'b11;
    a0 = 8'd1; b0 = 8'd1; func0 = RADD; a1 = 8'd2; b1 = 8'd2; func1 = RADD;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_done = (k % 3 != 1) ? 2'b00 : (((k / 3) % 2) != 0 ? 2'b10 : 2'b01);
      chk($sformatf("rr_done_k%0d", k), done, exp_done);
      chk($sformatf("rr_gnt_k%0d", k), gnt_id, (k / 3) % 2);
      if (k % 3 == 1)
        chk($sformatf("rr_result_k%0d", k), result, ((k / 3) % 2) != 0 ? 4 : 2);
    end
    req = 2'b00;
    @(negedge clk);

    // Reset during EXEC drops the operation; afterwards a tie goes to client 0.
    req = 2'b01; a0 = 8'd5; b0 = 8'd6; func0 = RADD;
    a1 = 8'd40; b1 = 8'd2; func1 = RADD;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1);
    reset = 1'b1; req = 2'b11;
    @(negedge clk);
    chk("mrst_done", done, 0);    chk("mrst_result", result, 0);
    chk("mrst_flag", flag, 0);    chk("mrst_gnt", gnt_id, 0);
    chk("mrst_busy", busy, 0);    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_b", alu_b, 0);  chk("mrst_alu_func", alu_func, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", gnt_id, 0);
    chk("post_rst_done", done, 0);
    @(negedge clk);
    chk("post_rst_done2", done, 2'b01);
    chk("post_rst_result", result, 8'd11);
    req = 2'b00;
    @(negedge clk);

    // Client 0 drops req during EXEC: still completes, no re-grant.
    req = 2'b01; a0 = 8'd9; b0 = 8'd4; func0 = RADD;
    @(negedge clk);
    chk("drop_exec_busy", busy, 1);
    req = 2'b00; a0 = 8'd0;
    @(negedge clk);
    chk("drop_done", done, 2'b01);
    chk("drop_result", result, 8'd13);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop_idle_busy%0d", k), busy, 0);
      chk($sformatf("drop_idle_done%0d", k), done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
